// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with synchronous reset, free-run
// clock enable, parallel load and a counted burst mode (BUSY/DONE).
//
// Parameters:
//   WIDTH  state width (3..32)
//   TAPS   feedback mask; bit i set puts state bit i into the XOR
//   SEED   reset / lockup-recovery state (nonzero)
//   CW     width of the burst length port
//
// Ports:
//   CLK     rising-edge clock
//   RESET   synchronous active-high reset
//   CE      free-run advance enable (IDLE only)
//   LOAD    load D into the state; aborts a running burst
//   D       parallel load value
//   START   burst request (IDLE only), LEN sampled with it
//   LEN     burst step count
//   O       current state
//   BUSY    burst in progress
//   DONE    one-cycle pulse when a burst completes
//   LOCKUP  one-cycle pulse on all-zero recovery (LFSR_GEN_LOCKUP_EN only)
//
// Macro LFSR_GEN_LOCKUP_EN enables all-zero detection and recovery to SEED.
// Without it an all-zero state persists until LOAD or RESET.

module lfsr_gen #(
  parameter int unsigned      WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = 6'b110000,
  parameter logic [WIDTH-1:0] SEED  = 6'b000001,
  parameter int unsigned      CW    = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [CW-1:0]    LEN,
  output logic [WIDTH-1:0] O,
  output logic             BUSY,
  output logic             DONE
`ifdef LFSR_GEN_LOCKUP_EN
  ,
  output logic             LOCKUP
`endif
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] adv;
  logic             recov;

`ifdef LFSR_GEN_LOCKUP_EN
  logic             lockup_q, lockup_d;
  assign recov = (o_q == '0);
`else
  assign recov = 1'b0;
`endif

  assign adv = {o_q[WIDTH-2:0], ^(o_q & TAPS)};

  // State register (also holds the registered outputs)
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      o_q      <= SEED;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef LFSR_GEN_LOCKUP_EN
      lockup_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      o_q      <= o_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef LFSR_GEN_LOCKUP_EN
      lockup_q <= lockup_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (LOAD) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START && (LEN != '0)) begin
            state_d = ST_RUN;
            rem_d   = LEN;
          end
        end
        ST_RUN: begin
          // A recovery edge is not a burst step, so the count holds.
          if (!recov) begin
            rem_d = rem_q - CW'(1);
            if (rem_q == CW'(1)) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic (values registered on the next edge)
  always_comb begin
    o_d    = o_q;
    done_d = 1'b0;
`ifdef LFSR_GEN_LOCKUP_EN
    lockup_d = 1'b0;
`endif
    if (LOAD) begin
      o_d = D;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START)   done_d = (LEN == '0);
          else if (CE) o_d    = adv;
        end
        ST_RUN: begin
          if (!recov) begin
            o_d    = adv;
            done_d = (rem_q == CW'(1));
          end
        end
        default: ;
      endcase
      if (recov) begin
        o_d = SEED;
`ifdef LFSR_GEN_LOCKUP_EN
        lockup_d = 1'b1;
`endif
      end
    end
    busy_d = (state_d == ST_RUN);
  end

  assign O    = o_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
`ifdef LFSR_GEN_LOCKUP_EN
  assign LOCKUP = lockup_q;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce = 1'b0;
  logic       load = 1'b0;
  logic [5:0] d = '0;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic [5:0] o;
  logic       busy;
  logic       done;
  logic       lk;

  always #5 clk = ~clk;

  lfsr_gen #(
    .WIDTH(6),
    .TAPS (6'b110000),
    .SEED (6'b000001),
    .CW   (8)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .CE    (ce),
    .LOAD  (load),
    .D     (d),
    .START (start),
    .LEN   (len),
    .O     (o),
    .BUSY  (busy),
    .DONE  (done)
`ifdef LFSR_GEN_LOCKUP_EN
    ,
    .LOCKUP(lk)
`endif
  );

`ifndef LFSR_GEN_LOCKUP_EN
  assign lk = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] o;
    logic       busy;
    logic       done;
    logic       lock;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: plain integers, remaining-step count instead of an FSM
  int m_o    = 1;
  int m_rem  = 0;
  bit m_done = 0;
  bit m_lock = 0;

  function automatic int lfsr_next(input int v);
    int ones;
    ones = $countones(v & 'h30);
    return (2 * v + (ones % 2)) % 64;
  endfunction

  task automatic step(input bit r, input bit c, input bit l, input int dv,
                      input bit s, input int ln);
    rst = r; ce = c; load = l; d = 6'(dv); start = s; len = 8'(ln);
    m_done = 0;
    m_lock = 0;
    if (r) begin
      m_o = 1; m_rem = 0;
    end else if (l) begin
      m_o = dv % 64; m_rem = 0;
    end else begin
`ifdef LFSR_GEN_LOCKUP_EN
      if (m_o == 0) begin
        m_o = 1; m_lock = 1;
        if (m_rem == 0 && s) begin
          if (ln == 0) m_done = 1; else m_rem = ln;
        end
      end else
`endif
      if (m_rem > 0) begin
        m_o = lfsr_next(m_o);
        m_rem--;
        m_done = (m_rem == 0);
      end else if (s) begin
        if (ln == 0) m_done = 1; else m_rem = ln;
      end else if (c) begin
        m_o = lfsr_next(m_o);
      end
    end
    @(posedge clk);
    q.push_back('{o: 6'(m_o), busy: (m_rem > 0), done: m_done, lock: m_lock});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every presented cycle against the queue
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if ({o, busy, done, lk} !== e) begin
        n_fail++;
        $display("FAIL scoreboard: got o=%h busy=%b done=%b lockup=%b, expected o=%h busy=%b done=%b lockup=%b",
                 o, busy, done, lk, e.o, e.busy, e.done, e.lock);
      end
    end
  end

  initial begin
    int exp6[6];
    bit seen[int];
    int first_ret;
    int dcount;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_o", o, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // First six CE steps
    exp6 = '{'h02, 'h04, 'h08, 'h10, 'h21, 'h03};
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk($sformatf("ce_seq%0d", i), o, exp6[i]);
    end

    // Full period from SEED
    step(1, 0, 0, 0, 0, 0);
    first_ret = 0;
    for (int i = 1; i <= 63; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (o == 6'h01 && first_ret == 0) first_ret = i;
      seen[int'(o)] = 1'b1;
    end
    chk("period_return", first_ret, 63);
    chk("period_distinct", seen.num(), 63);

    // Burst of 3 with CE held high
    step(0, 1, 0, 0, 1, 3);
    chk("burst_t_busy", busy, 1);
    chk("burst_t_o", o, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("burst_1_o", o, 'h02);
    step(0, 1, 0, 0, 0, 0);
    chk("burst_2_o", o, 'h04);
    chk("burst_2_busy", busy, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("burst_3_o", o, 'h08);
    chk("burst_3_busy", busy, 0);
    chk("burst_3_done", done, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("burst_after_done", done, 0);

    // LEN = 0
    step(0, 0, 0, 0, 1, 0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_o", o, 'h08);
    step(0, 0, 0, 0, 0, 0);
    chk("len0_done_clear", done, 0);

    // Abort by LOAD
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 10);
    idle(1);
    step(0, 0, 1, 'h2A, 1, 5);
    chk("abort_load_o", o, 'h2A);
    chk("abort_load_busy", busy, 0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0, 0);
      dcount += int'(done);
    end
    chk("abort_load_nodone", dcount, 0);

    // Abort by RESET
    step(0, 0, 0, 0, 1, 10);
    idle(1);
    step(1, 0, 0, 0, 0, 0);
    chk("abort_rst_o", o, 1);
    chk("abort_rst_busy", busy, 0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0, 0);
      dcount += int'(done);
    end
    chk("abort_rst_nodone", dcount, 0);

    // All-zero state
    step(0, 0, 1, 0, 0, 0);
    chk("zero_load_o", o, 0);
`ifdef LFSR_GEN_LOCKUP_EN
    step(0, 1, 0, 0, 0, 0);
    chk("lockup_o", o, 1);
    chk("lockup_pulse", lk, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("lockup_clear", lk, 0);
`else
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk($sformatf("zero_hold%0d", i), o, 0);
    end
    step(1, 0, 0, 0, 0, 0);
`endif

    // Maximum LEN followed by a back-to-back START in the DONE cycle
    step(0, 0, 0, 0, 1, 255);
    dcount = 0;
    for (int i = 0; i < 255; i++) begin
      step(0, 1, 0, 0, 0, 0);
      dcount += int'(busy);
    end
    chk("maxlen_busy_cycles", dcount, 254);
    chk("maxlen_done", done, 1);
    step(0, 0, 0, 0, 1, 2);
    chk("b2b_busy", busy, 1);
    idle(2);
    chk("b2b_done", done, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit r, c, l, s;
      int dv, ln;
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 19) == 0);
      dv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63));
      s  = ($urandom_range(0, 7) == 0);
      ln = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      c  = $urandom_range(0, 1) == 1;
      step(r, c, l, dv, s, ln);
    end

    idle(2);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
